// File: rtl/complete_stage_pkg.sv
// Shared types for the complete stage: FU output register format and CDB slot format.
package complete_stage_pkg;

   localparam int unsigned XLEN          = 32;
   localparam int unsigned PR_W          = 6;
   localparam int unsigned ROB_W         = 5;
   localparam int unsigned CDB_W_DEFAULT = 2;

   typedef struct packed {
      logic             if_take_branch;
      logic             valid;
      logic             halt;
      logic [XLEN-1:0]  target_pc;
      logic [PR_W-1:0]  dest_pr;
      logic [XLEN-1:0]  dest_value;
      logic [ROB_W-1:0] rob_entry;
   } FU_COMPLETE_PACKET;

   typedef struct packed {
      logic             valid;
      logic [PR_W-1:0]  dest_pr;
      logic [XLEN-1:0]  dest_value;
      logic [ROB_W-1:0] rob_entry;
      logic             if_take_branch;
      logic [XLEN-1:0]  target_pc;
      logic             halt;
   } CDB_PACKET;

   function automatic CDB_PACKET fu_to_cdb(input FU_COMPLETE_PACKET p);
      CDB_PACKET c;
      c.valid          = p.valid;
      c.dest_pr        = p.dest_pr;
      c.dest_value     = p.dest_value;
      c.rob_entry      = p.rob_entry;
      c.if_take_branch = p.if_take_branch;
      c.target_pc      = p.target_pc;
      c.halt           = p.halt;
      return c;
   endfunction

endpackage

// File: rtl/complete_stage_rr_grant_n.sv
// N-of-M round-robin grant: walks requesters from ptr_i with wrap, granting up to avail_i of them.
module rr_grant_n #(
   parameter  int unsigned M  = 3,
   parameter  int unsigned N  = 2,
   localparam int unsigned PW = (M > 1) ? $clog2(M) : 1,
   localparam int unsigned CW = $clog2(N + 1)
) (
   input  logic [M-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   input  logic [CW-1:0] avail_i,
   output logic [M-1:0]  grant_o,
   output logic          grant_any_o,
   output logic [PW-1:0] last_o
);

   int unsigned idx;
   int unsigned cnt;

   always_comb begin
      grant_o = '0;
      last_o  = ptr_i;
      cnt     = 0;
      idx     = 0;
      for (int unsigned k = 0; k < M; k++) begin
         idx = 32'(ptr_i) + k;
         if (idx >= M) idx = idx - M;
         if (req_i[idx] && (cnt < 32'(avail_i))) begin
            grant_o[idx] = 1'b1;
            last_o       = PW'(idx);
            cnt          = cnt + 1;
         end
      end
   end

   assign grant_any_o = |grant_o;

endmodule

// File: rtl/complete_stage.sv
// Complete stage: branch-first, round-robin arbitration of FU results onto a registered CDB.
module complete_stage
   import complete_stage_pkg::*;
#(
   parameter int unsigned NUM_FU = 4,
   parameter int unsigned CDB_W  = CDB_W_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NUM_FU-1:0] want_to_complete,
   input  FU_COMPLETE_PACKET fu_packet_in [NUM_FU],
   input  logic              squash,
   output logic [NUM_FU-1:0] complete_stall,
   output CDB_PACKET         cdb_packet_out [CDB_W],
   output logic              br_resolve_valid
);

   localparam int unsigned NR  = NUM_FU - 1;
   localparam int unsigned PW  = (NR > 1) ? $clog2(NR) : 1;
   localparam int unsigned FPW = $clog2(NUM_FU);
   localparam int unsigned CW  = $clog2(CDB_W + 1);

   logic [NUM_FU-1:0] elig;
   logic [NUM_FU-1:0] granted;
   logic              br_grant;
   logic [NR-1:0]     rr_grant;
   logic              rr_any;
   logic [PW-1:0]     rr_last;
   logic [PW-1:0]     sub_ptr;
   logic [CW-1:0]     avail;

   logic [FPW-1:0]    rr_ptr_q, rr_ptr_d;
   CDB_PACKET         cdb_q [CDB_W];
   CDB_PACKET         cdb_d [CDB_W];
   logic              br_q;

   always_comb begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
         elig[i] = want_to_complete[i] && fu_packet_in[i].valid;
      end
   end

   assign br_grant = elig[0];
   assign avail    = CW'(CDB_W) - CW'(br_grant);
   // rr_ptr holds an FU index (1..NUM_FU-1); the arbiter works on 0-based sub-indices.
   assign sub_ptr  = PW'(rr_ptr_q - FPW'(1));

   rr_grant_n #(
      .M(NR),
      .N(CDB_W)
   ) u_rr (
      .req_i       (elig[NUM_FU-1:1]),
      .ptr_i       (sub_ptr),
      .avail_i     (avail),
      .grant_o     (rr_grant),
      .grant_any_o (rr_any),
      .last_o      (rr_last)
   );

   assign granted = {rr_grant, br_grant};

   always_comb begin
      if (!reset || squash) complete_stall = '0;
      else                  complete_stall = elig & ~granted;
   end

   int unsigned nslot;
   int unsigned idx;
   int unsigned nxt;

   // Slots are packed branch first, then in round-robin visit order.
   always_comb begin
      for (int unsigned s = 0; s < CDB_W; s++) cdb_d[s] = '0;
      nslot = 0;
      idx   = 0;
      if (br_grant) begin
         cdb_d[0] = fu_to_cdb(fu_packet_in[0]);
         nslot    = 1;
      end
      for (int unsigned k = 0; k < NR; k++) begin
         idx = 32'(sub_ptr) + k;
         if (idx >= NR) idx = idx - NR;
         if (rr_grant[idx] && (nslot < CDB_W)) begin
            cdb_d[nslot] = fu_to_cdb(fu_packet_in[idx + 1]);
            nslot        = nslot + 1;
         end
      end
   end

   always_comb begin
      nxt = 32'(rr_last) + 2;
      if (nxt > NR) nxt = 1;
      rr_ptr_d = rr_any ? FPW'(nxt) : rr_ptr_q;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int unsigned s = 0; s < CDB_W; s++) cdb_q[s] <= '0;
         br_q     <= 1'b0;
         rr_ptr_q <= FPW'(1);
      end else if (squash) begin
         for (int unsigned s = 0; s < CDB_W; s++) cdb_q[s] <= '0;
         br_q     <= 1'b0;
      end else begin
         for (int unsigned s = 0; s < CDB_W; s++) cdb_q[s] <= cdb_d[s];
         br_q     <= br_grant;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign cdb_packet_out   = cdb_q;
   assign br_resolve_valid = br_q;

endmodule

// File: tb/tb_complete_stage.sv
// Directed table-driven bench for complete_stage (NUM_FU=4, CDB_W=2).
module tb_complete_stage;
   import complete_stage_pkg::*;

   logic              clock;
   logic              reset;
   logic [3:0]        want;
   FU_COMPLETE_PACKET fu_pkt [4];
   logic              squash;
   logic [3:0]        stall;
   CDB_PACKET         cdb [2];
   logic              br_valid;

   int checks   = 0;
   int failures = 0;

   complete_stage #(
      .NUM_FU(4),
      .CDB_W (2)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .want_to_complete (want),
      .fu_packet_in     (fu_pkt),
      .squash           (squash),
      .complete_stall   (stall),
      .cdb_packet_out   (cdb),
      .br_resolve_valid (br_valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [3:0] want;
      logic       sq;
      logic [3:0] stall;
      int         s0;
      int         s1;
      logic       br;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic FU_COMPLETE_PACKET mk_pkt(input int fu, input int v, input logic vld);
      FU_COMPLETE_PACKET p;
      p.valid          = vld;
      p.if_take_branch = (fu == 0) && (v % 2 == 0);
      p.halt           = (v == 8) && (fu == 1);
      p.target_pc      = 32'(v * 8 + 8);
      p.dest_pr        = 6'(32 + fu + v);
      p.dest_value     = 32'(v * 4096 + fu * 16 + 1);
      p.rob_entry      = 5'(v * 4 + fu);
      return p;
   endfunction

   function automatic CDB_PACKET exp_cdb(input FU_COMPLETE_PACKET p);
      CDB_PACKET c;
      c.valid          = 1'b1;
      c.dest_pr        = p.dest_pr;
      c.dest_value     = p.dest_value;
      c.rob_entry      = p.rob_entry;
      c.if_take_branch = p.if_take_branch;
      c.target_pc      = p.target_pc;
      c.halt           = p.halt;
      return c;
   endfunction

   task automatic chk_slot(input string name, input CDB_PACKET act, input int fu, input int v);
      if (fu < 0) chk(name, 128'(act.valid), 128'(0));
      else        chk(name, 128'(act), 128'(exp_cdb(mk_pkt(fu, v, 1'b1))));
   endtask

   task automatic drive(input logic [3:0] w, input int v);
      want = w;
      for (int i = 0; i < 4; i++) fu_pkt[i] = mk_pkt(i, v, w[i]);
   endtask

   initial begin
      tbl[0]  = '{4'b0001, 1'b0, 4'b0000,  0, -1, 1'b1};
      tbl[1]  = '{4'b1111, 1'b0, 4'b1100,  0,  1, 1'b1};
      tbl[2]  = '{4'b1100, 1'b0, 4'b0000,  2,  3, 1'b0};
      tbl[3]  = '{4'b1110, 1'b0, 4'b1000,  1,  2, 1'b0};
      tbl[4]  = '{4'b1110, 1'b0, 4'b0100,  3,  1, 1'b0};
      tbl[5]  = '{4'b1110, 1'b0, 4'b0010,  2,  3, 1'b0};
      tbl[6]  = '{4'b0110, 1'b1, 4'b0000, -1, -1, 1'b0};
      tbl[7]  = '{4'b1110, 1'b0, 4'b1000,  1,  2, 1'b0};
      tbl[8]  = '{4'b0011, 1'b0, 4'b0000,  0,  1, 1'b1};
      tbl[9]  = '{4'b0000, 1'b0, 4'b0000, -1, -1, 1'b0};
      tbl[10] = '{4'b0111, 1'b0, 4'b0010,  0,  2, 1'b1};

      // Reset held two cycles with every FU requesting.
      reset  = 1'b0;
      squash = 1'b0;
      drive(4'b1111, 0);
      #1;
      for (int c = 0; c < 2; c++) begin
         #2;
         chk("reset_stall", 128'(stall), 128'(0));
         @(posedge clock);
         #1;
      end
      chk("reset_cdb0_valid", 128'(cdb[0].valid), 128'(0));
      chk("reset_cdb1_valid", 128'(cdb[1].valid), 128'(0));
      chk("reset_cdb0_zero", 128'(cdb[0]), 128'(0));
      chk("reset_br", 128'(br_valid), 128'(0));
      reset = 1'b1;
      drive(4'b0000, 0);
      #2;
      chk("reset_rr_ptr", 128'(dut.rr_ptr_q), 128'(1));

      for (int v = 0; v < 11; v++) begin
         drive(tbl[v].want, v);
         squash = tbl[v].sq;
         #2;
         chk($sformatf("v%0d_stall", v), 128'(stall), 128'(tbl[v].stall));
         @(posedge clock);
         #1;
         chk_slot($sformatf("v%0d_slot0", v), cdb[0], tbl[v].s0, v);
         chk_slot($sformatf("v%0d_slot1", v), cdb[1], tbl[v].s1, v);
         chk($sformatf("v%0d_br", v), 128'(br_valid), 128'(tbl[v].br));
         squash = 1'b0;
      end

      // Hold-stable: FU3 loses once, then broadcasts its held packet unchanged.
      drive(4'b1000, 20);
      #2;
      chk("hold_pre_stall", 128'(stall), 128'(0));
      @(posedge clock);
      #1;
      chk_slot("hold_pre_slot0", cdb[0], 3, 20);
      drive(4'b1011, 21);
      fu_pkt[3] = '{if_take_branch: 1'b0, valid: 1'b1, halt: 1'b0, target_pc: 32'd0,
                    dest_pr: 6'd20, dest_value: 32'd144, rob_entry: 5'd7};
      #2;
      chk("hold_a_stall", 128'(stall), 128'(4'b1000));
      @(posedge clock);
      #1;
      chk_slot("hold_a_slot0", cdb[0], 0, 21);
      chk_slot("hold_a_slot1", cdb[1], 1, 21);
      want      = 4'b1000;
      fu_pkt[0] = mk_pkt(0, 22, 1'b0);
      fu_pkt[1] = mk_pkt(1, 22, 1'b0);
      #2;
      chk("hold_b_stall", 128'(stall), 128'(0));
      @(posedge clock);
      #1;
      chk("hold_b_valid", 128'(cdb[0].valid), 128'(1));
      chk("hold_b_value", 128'(cdb[0].dest_value), 128'(144));
      chk("hold_b_rob", 128'(cdb[0].rob_entry), 128'(7));
      chk("hold_b_slot1", 128'(cdb[1].valid), 128'(0));
      chk("hold_b_br", 128'(br_valid), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/complete_stage.md
# complete_stage

Complete stage of the out-of-order core, sitting directly downstream of the functional-unit stages (branch, ALUs, multiplier). Each cycle it arbitrates FU completion requests onto a CDB_W-wide common data bus. It returns a per-FU `complete_stall` so that losing FUs hold their output registers. Granted results are registered and broadcast one cycle later to the ROB (completion and branch resolution) and to the RS and map table (wakeup).

## Interface
Parameters:
- `NUM_FU`, default 4: number of completing FUs. Index 0 is the branch FU; indices 1..NUM_FU-1 are the others.
- `CDB_W`, default 2: CDB slots per cycle; must satisfy 1 ≤ CDB_W ≤ NUM_FU.

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low: reset is applied at a posedge while `reset`==0.
- `want_to_complete`  in  NUM_FU  request vector; bit i asserted only while `fu_packet_in[i].valid`==1.
- `fu_packet_in`  in  FU_COMPLETE_PACKET[NUM_FU]  FU output registers (if_take_branch, valid, halt, target_pc, dest_pr, dest_value, rob_entry).
- `squash`  in  1  ROB mispredict flush.
- `complete_stall`  out  NUM_FU  combinational; 1 = FU requested and was not granted this cycle.
- `cdb_packet_out`  out  CDB_PACKET[CDB_W]  registered CDB slots.
- `br_resolve_valid`  out  1  registered; the branch FU result is on the CDB this cycle.

## Operation
- Eligible set: FU i is eligible iff `want_to_complete[i]` && `fu_packet_in[i].valid`.
- Branch priority: if FU 0 is eligible, it always takes slot 0.
- Round-robin fill: the remaining slots are filled from FUs 1..NUM_FU-1 in round-robin order, starting at `rr_ptr`. The search wraps from NUM_FU-1 to 1 and never selects index 0.
- Slot packing: granted packets are packed into slots 0.. with no holes. Slots beyond the grant count have valid=0.
- Stall: `complete_stall[i]` = eligible[i] && !granted[i]. A stalled FU holds its packet unchanged; it is re-arbitrated next cycle.
- Pointer update: `rr_ptr` ← (last granted non-branch index + 1), wrapping within 1..NUM_FU-1. If no non-branch FU is granted, `rr_ptr` is unchanged.
- CDB_PACKET contents: valid, dest_pr, dest_value, rob_entry, if_take_branch, target_pc, halt. Fields are copied verbatim from the granted packet.
- `br_resolve_valid` = 1 in the cycle slot 0 carries the FU 0 result.
- Squash: on a posedge where `squash`==1, all CDB slot valids and `br_resolve_valid` are cleared (0 the next cycle). `complete_stall` is forced to 0 in the squash cycle. `rr_ptr` is held. Same-cycle requests are dropped, because the FUs flush too.
- Reset (at posedge with `reset`==0): all `cdb_packet_out` fields ← 0, `br_resolve_valid` ← 0, `rr_ptr` ← 1. `complete_stall` is forced to 0 while `reset`==0.

## Timing
- Arbitration is combinational within cycle t. Stall reaches the FUs before the posedge of t.
- The CDB is valid from the posedge ending t, so latency is 1 cycle from request to broadcast.
- If eligible count ≤ CDB_W, there are no stalls that cycle.
- Simultaneous squash and requests: squash wins and the CDB is empty at t+1.
- Reset dominates squash.
- Back-to-back grants to the same FU on consecutive cycles are legal when that FU produces a new packet each cycle.
- Single-slot case: with CDB_W=1, an eligible branch starves the other FUs that cycle. This is acceptable because branch issue is limited to one per cycle.

## Structure
- `sys_defs.svh` gains the `CDB_PACKET` typedef and the `CDB_W` default constant. `FU_COMPLETE_PACKET` is reused unchanged.
- Sub-module `rr_grant_n`: parameterised N-of-M round-robin grant with a pointer input and a one-hot grant-vector output. `complete_stage` instantiates it over FUs 1..NUM_FU-1 with CDB_W−(branch granted) available slots.
- The `rr_ptr` register and the CDB output registers live in `complete_stage`.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with all FUs requesting. Required: CDB valids 0, `complete_stall`=0000, `br_resolve_valid`=0. After release, `rr_ptr`=1.
- Branch-only completion: FU0 sends a taken branch (target_pc=8, dest_pr=32, rob_entry=0). Required: next cycle slot0 valid, if_take_branch=1, target_pc=8, `br_resolve_valid`=1; stall=0000.
- Over-subscription: with CDB_W=2, FUs 0,1,2,3 all request with `rr_ptr`=1. Required: slots carry FU0 and FU1; stall=1100 (FU3, FU2). Next cycle, with FUs 2 and 3 still holding: slots carry FU2 and FU3, stall=0000.
- Round-robin fairness: FUs 1,2,3 request continuously with fresh packets. Required grants: {1,2}, {3,1}, {2,3}. No FU waits more than 1 cycle.
- Squash collision: FUs 1 and 2 request while `squash`=1. Required: next cycle all CDB valids 0, stall=000, `rr_ptr` unchanged.
- Hold-stable check: a stalled FU's dest_value (e.g. 144) is broadcast unmodified when it is later granted, with the same rob_entry.
